rf_wb_arb: RTL and testbench

Write-back arbiter and buffer that is the producer side of the register file's single write port. It accepts results from two sources, the ALU pipe and memory/cache load return, each with a valid/ready handshake. Results are queued in program order and drained at one register write per cycle into the rf write port. It also reports pending writes for the decode-stage read selects, so hazard logic can stall.

---
 rtl/rf_wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 79 +++++++
 rtl/rf_wb_arb.sv | 96 +++++++++
 tb/tb_rf_wb_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths and the write-back entry payload for the register-file write arbiter.
package rf_wb_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SEL_W    = $clog2(NUM_REGS);

  typedef struct packed {
    logic [SEL_W-1:0]  regsel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries: up to two enqueues and one dequeue per cycle,
// plus per-entry register-select match against two lookup selects.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_a,
  input  wb_entry_t        entry_a,
  input  logic             push_b,
  input  wb_entry_t        entry_b,
  input  logic             pop,
  input  logic [SEL_W-1:0] rsel1,
  input  logic [SEL_W-1:0] rsel2,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        head_c,
  output logic             match1_c,
  output logic             match2_c
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] off;

  // entry_b only lands when entry_a does, directly behind it
  always_comb begin
    mem_d  = mem_q;
    tail_d = tail_q;
    if (push_a) begin
      mem_d[tail_q] = entry_a;
      tail_d        = PTR_W'(tail_q + PTR_W'(1));
      if (push_b) begin
        mem_d[tail_d] = entry_b;
        tail_d        = PTR_W'(tail_d + PTR_W'(1));
      end
    end
    head_d  = pop ? PTR_W'(head_q + PTR_W'(1)) : head_q;
    count_d = CNT_W'(count_q + CNT_W'(push_a) + CNT_W'(push_a & push_b) - CNT_W'(pop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // a slot is occupied when its distance from head is below count
  always_comb begin
    match1_c = 1'b0;
    match2_c = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PTR_W'(PTR_W'(i) - head_q);
      if (CNT_W'(off) < count_q) begin
        if (mem_q[i].regsel == rsel1) match1_c = 1'b1;
        if (mem_q[i].regsel == rsel2) match2_c = 1'b1;
      end
    end
  end

  assign count  = count_q;
  assign head_c = mem_q[head_q];

endmodule

// File: rtl/rf_wb_arb.sv
// Write-back arbiter feeding the register file's single write port from ALU and load returns.
// Optional RF_WB_FLOWTHRU_EN: a lone result arriving at an empty queue is written in the same cycle.
module rf_wb_arb
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [SEL_W-1:0]  mem_regsel,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [SEL_W-1:0]  alu_regsel,
  input  logic [DATA_W-1:0] alu_data,
  output logic              write,
  output logic [SEL_W-1:0]  writeregsel,
  output logic [DATA_W-1:0] writedata,
  input  logic [SEL_W-1:0]  read1regsel,
  input  logic [SEL_W-1:0]  read2regsel,
  output logic              read1_pending,
  output logic              read2_pending,
  output logic              err
);

  logic [CNT_W-1:0] count;
  wb_entry_t        head_c, mem_ent, alu_ent, entry_a;
  logic             ready_c, mem_xfer, alu_xfer;
  logic             push_a, push_b, pop;
  logic             match1_c, match2_c;
  logic             err_q, err_d;

  assign mem_ent = {mem_regsel, mem_data};
  assign alu_ent = {alu_regsel, alu_data};

  // two free slots keep a same-cycle pair from ever overflowing
  assign ready_c   = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign mem_ready = ready_c;
  assign alu_ready = ready_c;
  assign pop       = (count != '0);

  // mem wins the first slot of a same-cycle pair
  always_comb begin
    mem_xfer    = mem_valid & ready_c;
    alu_xfer    = alu_valid & ready_c;
    push_a      = mem_xfer | alu_xfer;
    entry_a     = mem_xfer ? mem_ent : alu_ent;
    push_b      = mem_xfer & alu_xfer;
    write       = (count != '0);
    writeregsel = head_c.regsel;
    writedata   = head_c.data;
`ifdef RF_WB_FLOWTHRU_EN
    if ((count == '0) && push_a) begin
      write       = 1'b1;
      writeregsel = entry_a.regsel;
      writedata   = entry_a.data;
      push_a      = push_b;
      entry_a     = alu_ent;
      push_b      = 1'b0;
    end
`endif
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a   (push_a),
    .entry_a  (entry_a),
    .push_b   (push_b),
    .entry_b  (alu_ent),
    .pop      (pop),
    .rsel1    (read1regsel),
    .rsel2    (read2regsel),
    .count    (count),
    .head_c   (head_c),
    .match1_c (match1_c),
    .match2_c (match2_c)
  );

  assign read1_pending = match1_c;
  assign read2_pending = match2_c;

  // sticky: any offer while not ready
  assign err_d = err_q | ((mem_valid | alu_valid) & ~ready_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Randomized bench for rf_wb_arb against a queue-based model of the write-back order.
module tb_rf_wb_arb;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic        mem_ready, alu_ready;
  logic [2:0]  mem_regsel, alu_regsel;
  logic [15:0] mem_data, alu_data;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [2:0]  read1regsel, read2regsel;
  logic        read1_pending, read2_pending;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [18:0] mq[$];
  bit          m_err;

  rf_wb_arb #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_regsel    (mem_regsel),
    .mem_data      (mem_data),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_regsel    (alu_regsel),
    .alu_data      (alu_data),
    .write         (write),
    .writeregsel   (writeregsel),
    .writedata     (writedata),
    .read1regsel   (read1regsel),
    .read2regsel   (read2regsel),
    .read1_pending (read1_pending),
    .read2_pending (read2_pending),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (DEPTH - mq.size()) >= 2;
  endfunction

  task automatic check_outputs();
    bit          ew, p1, p2, mx, ax;
    logic [18:0] ee;
    mx = mem_valid && m_ready();
    ax = alu_valid && m_ready();
    ew = (mq.size() != 0);
    ee = ew ? mq[0] : 19'd0;
`ifdef RF_WB_FLOWTHRU_EN
    if (!ew && (mx || ax)) begin
      ew = 1'b1;
      ee = mx ? {mem_regsel, mem_data} : {alu_regsel, alu_data};
    end
`endif
    p1 = 1'b0;
    p2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i][18:16] == read1regsel) p1 = 1'b1;
      if (mq[i][18:16] == read2regsel) p2 = 1'b1;
    end
    check("mem_ready", 32'(mem_ready), 32'(m_ready()));
    check("alu_ready", 32'(alu_ready), 32'(m_ready()));
    check("write", 32'(write), 32'(ew));
    if (ew) begin
      check("writeregsel", 32'(writeregsel), 32'(ee[18:16]));
      check("writedata", 32'(writedata), 32'(ee[15:0]));
    end
    check("read1_pending", 32'(read1_pending), 32'(p1));
    check("read2_pending", 32'(read2_pending), 32'(p2));
    check("err", 32'(err), 32'(m_err));
  endtask

  // one clock edge of the model: drain head, then append accepted results in order
  task automatic model_update();
    bit rdy, mx, ax, was_empty;
    rdy = m_ready();
    mx  = mem_valid && rdy;
    ax  = alu_valid && rdy;
    if ((mem_valid || alu_valid) && !rdy) m_err = 1'b1;
    was_empty = (mq.size() == 0);
    if (!was_empty) void'(mq.pop_front());
`ifdef RF_WB_FLOWTHRU_EN
    if (was_empty) begin
      if (mx && ax) mq.push_back({alu_regsel, alu_data});
    end else begin
      if (mx) mq.push_back({mem_regsel, mem_data});
      if (ax) mq.push_back({alu_regsel, alu_data});
    end
`else
    if (mx) mq.push_back({mem_regsel, mem_data});
    if (ax) mq.push_back({alu_regsel, alu_data});
`endif
  endtask

  task automatic step(input logic mv, input logic [2:0] ms, input logic [15:0] md,
                      input logic av, input logic [2:0] as_, input logic [15:0] ad);
    mem_valid  = mv;
    mem_regsel = ms;
    mem_data   = md;
    alu_valid  = av;
    alu_regsel = as_;
    alu_data   = ad;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
  endtask

  task automatic check_reset_state();
    check("rst_write", 32'(write), 32'd0);
    check("rst_writeregsel", 32'(writeregsel), 32'd0);
    check("rst_writedata", 32'(writedata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd1);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_read1_pending", 32'(read1_pending), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    mem_valid = 1'b0; mem_regsel = '0; mem_data = '0;
    alu_valid = 1'b0; alu_regsel = '0; alu_data = '0;
    read1regsel = '0; read2regsel = '0;
    m_err = 1'b0;

    // reset held two cycles, then idle
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b1;
    idle(5);

    // single ALU result, pending tracked on read1
    read1regsel = 3'd3;
    step(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'hBEEF);
    idle(3);

    // same-cycle pair: mem first, then alu
    read2regsel = 3'd5;
    step(1'b1, 3'd2, 16'h1111, 1'b1, 3'd5, 16'h2222);
    idle(4);

    // both sources offering whenever ready
    for (int k = 0; k < 10; k++) begin
      bit v;
      v = m_ready();
      step(v, 3'(k), 16'(16'h1000 + k), v, 3'(k + 4), 16'(16'h2000 + k));
    end
    idle(4);

    // random traffic respecting ready
    for (int k = 0; k < 300; k++) begin
      bit mv, av;
      read1regsel = 3'($urandom_range(0, 7));
      read2regsel = 3'($urandom_range(0, 7));
      mv = ($urandom_range(0, 1) == 1) && m_ready();
      av = ($urandom_range(0, 1) == 1) && m_ready();
      step(mv, 3'($urandom_range(0, 7)), 16'($urandom), av, 3'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(4);

    // protocol violation: offer alu while not ready
    for (int k = 0; k < 6 && m_ready(); k++)
      step(1'b1, 3'd1, 16'(16'h3000 + k), 1'b1, 3'd2, 16'(16'h4000 + k));
    read1regsel = 3'd7;
    step(1'b0, 3'd0, 16'd0, 1'b1, 3'd7, 16'hDEAD);
    idle(6);

    // async reset in the middle of a drain
    step(1'b1, 3'd4, 16'h5555, 1'b1, 3'd6, 16'h6666);
    step(1'b1, 3'd1, 16'h7777, 1'b1, 3'd3, 16'h8888);
    read1regsel = 3'd3;
    read2regsel = 3'd6;
    @(negedge clk);
    check_outputs();
    #2;
    rst = 1'b0;
    #1;
    check_reset_state();
    check("rst_read2_pending", 32'(read2_pending), 32'd0);
    mq.delete();
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);

    // single ALU result into an empty queue after reset
    step(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'hCAFE);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
